spi_master: RTL and testbench
=============================

# spi_master

Single-byte SPI master, Mode 0 (CPOL=0, CPHA=0), MSB first, running from one system clock. It is the initiator end of the SPI link: it drives CS, SCLK and MOSI to an off-block Mode-0 slave and captures MISO. Internal logic requests a byte transfer with a one-cycle start strobe and gets back the received byte with a one-cycle done pulse. All SPI outputs are registered; SCLK is derived by counting system clocks, not by a second clock domain.

## Interface
- HALF_PERIOD, 4, system-clock cycles per SCLK half period; legal ≥ 2
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  transfer request; sampled only while busy=0
- tx_data  in  8  byte to send; latched on the edge that accepts start
- busy  out  1  high from accept until the inter-frame gap completes
- done  out  1  one-cycle pulse; rx_data valid in the same cycle
- rx_data  out  8  last received byte; holds until the next done
- sclk  out  1  SPI clock, idles low
- cs  out  1  active-low chip select, idles high
- mosi  out  1  master-to-slave data
- miso  in  1  slave-to-master data; synchronous to sclk, no synchronizer needed at supported rates

## Operation
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00; FSM to IDLE; counters cleared.
- FSM states: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP.
- IDLE: on start=1, latch tx_data into tx shift register, cs←0, mosi←tx_data[7], busy←1, bit counter←0, then go to SETUP.
- SETUP: wait HALF_PERIOD cycles, then sclk←1, sample miso into rx shift LSB, and go to SCLK_HI.
- SCLK_HI: wait HALF_PERIOD cycles, then sclk←0. If the bit counter is below 7, shift tx, mosi←next bit, increment the counter, and go to SCLK_LO. If the bit counter is 7, mosi holds and the FSM goes to HOLD.
- SCLK_LO: wait HALF_PERIOD cycles, then sclk←1, sample miso, and go to SCLK_HI.
- HOLD: wait HALF_PERIOD cycles with cs low, then cs←1, rx_data←rx shift register, done←1 for one cycle, and go to GAP.
- GAP: wait HALF_PERIOD cycles with cs high, then busy←0 and go to IDLE.
- Each frame has exactly 8 rising and 8 falling sclk edges. The rx shift is {rx[6:0], miso}, so the first-sampled bit ends in rx_data[7].
- start while busy=1 is ignored, with no queueing; tx_data changes while busy have no effect.
- Reset mid-frame: on the next edge all outputs return to their reset values. done is not pulsed, the partial byte is discarded, and rx_data is cleared to 8'h00.
- Half-period counter width is $clog2(HALF_PERIOD); the bit counter is 3 bits, with no wrap in use.

## Timing
- H=HALF_PERIOD. T0 is the clk edge that accepts start.
- After T0: cs=0, busy=1, mosi=bit7.
- Rising sclk k (k=1..8) occurs after edge T0+(2k−1)H, and miso is sampled on that edge.
- Falling sclk k occurs after edge T0+2kH. mosi changes to bit 7−k in the same cycle, for k=1..7 only.
- cs rises, done=1 and rx_data updates after edge T0+17H.
- busy=0 after edge T0+18H. The earliest next accept is edge T0+18H+1.
- With H=4: cs rises after T0+68, busy falls after T0+72, and frame-to-frame spacing is 73 cycles minimum.
- mosi is stable for ≥H cycles on both sides of every rising sclk. cs is low ≥H cycles before the first rising edge and after the last falling edge.

## Structure
- Shared package spi_pkg holds:
  - the FSM state enum (IDLE…GAP)
  - the SPI_MODE0 constants: CPOL=0, CPHA=0
  - the default HALF_PERIOD and frame width 8
- The natural sub-module is spi_sclk_tick. It is a half-period down-counter with a clear input and a one-cycle tick output, used for every wait state. The rest of the FSM lives in spi_master.

## Test plan
- Reset: assert reset 3 cycles, including once mid-frame → cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00 on the following edge.
- Loopback (miso tied to mosi), H=4, tx_data=8'hA5 → exactly 8 sclk rising edges, done after T0+68, rx_data=8'hA5, busy low after T0+72.
- Mode-0 slave model returns 8'h3C, tx_data=8'hC3 → mosi sampled at rising edges = 1,1,0,0,0,0,1,1; rx_data=8'h3C; slave captures 8'hC3.
- start pulse with tx_data=8'hFF at T0+10 while busy → ignored; the frame still transmits the first byte, and only one done pulse occurs.
- reset asserted at T0+20 → cs=1 next cycle, no done; new start with 8'h81 afterwards completes with a loopback rx_data=8'h81.
- start held high continuously, H=2 → second cs fall after edge T0+37, two done pulses 37 cycles apart, cs high for ≥H cycles between frames.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, Mode-0 constants and frame sizing for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, GAP} state_t;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
  localparam int DEFAULT_HALF_PERIOD = 4;
  localparam int FRAME_BITS = 8;
endpackage

// File: rtl/spi_sclk_tick.sv
// spi_sclk_tick: half-period down-counter, ticks in the last cycle of every wait state
module spi_sclk_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(HALF_PERIOD);
  localparam logic [W-1:0] LOAD = W'(HALF_PERIOD - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= LOAD;
    else cnt <= cnt - 1'b1;
  assign tick = cnt == '0;
endmodule

// File: rtl/spi_master.sv
// spi_master: single-byte Mode-0 SPI master, MSB first, with registered SPI outputs
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);
  state_t state, state_d;
  logic tick;
  logic [6:0] tx_sr, tx_sr_d;
  logic [7:0] rx_sr, rx_sr_d, rx_data_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic sclk_d, cs_d, mosi_d, busy_d, done_d;
  // The counter reloads while idle and on every tick, so each wait lasts exactly HALF_PERIOD cycles
  spi_sclk_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE || tick),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      tx_sr <= '0;
      rx_sr <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      sclk <= CPOL;
      cs <= 1'b1;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      tx_sr <= tx_sr_d;
      rx_sr <= rx_sr_d;
      rx_data <= rx_data_d;
      bit_cnt <= bit_cnt_d;
      sclk <= sclk_d;
      cs <= cs_d;
      mosi <= mosi_d;
      busy <= busy_d;
      done <= done_d;
    end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = start ? SETUP : IDLE;
      SETUP, SCLK_LO: state_d = tick ? SCLK_HI : state;
      SCLK_HI: state_d = tick ? (bit_cnt == LAST_BIT ? HOLD : SCLK_LO) : state;
      HOLD: state_d = tick ? GAP : state;
      GAP: state_d = tick ? IDLE : state;
      default: state_d = IDLE;
    endcase
  end
  // tx_sr holds only the bits still to be sent; bit 7 goes straight to mosi on accept
  always_comb begin
    tx_sr_d = tx_sr;
    rx_sr_d = rx_sr;
    rx_data_d = rx_data;
    bit_cnt_d = bit_cnt;
    sclk_d = sclk;
    cs_d = cs;
    mosi_d = mosi;
    busy_d = busy;
    done_d = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          tx_sr_d = tx_data[6:0];
          cs_d = 1'b0;
          mosi_d = tx_data[7];
          busy_d = 1'b1;
          bit_cnt_d = '0;
        end
      SETUP, SCLK_LO:
        if (tick) begin
          sclk_d = 1'b1;
          rx_sr_d = {rx_sr[6:0], miso};
        end
      SCLK_HI:
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_cnt != LAST_BIT) begin
            tx_sr_d = {tx_sr[5:0], 1'b0};
            mosi_d = tx_sr[6];
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      HOLD:
        if (tick) begin
          cs_d = 1'b1;
          rx_data_d = rx_sr;
          done_d = 1'b1;
        end
      GAP:
        if (tick) busy_d = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master at HALF_PERIOD 4 and 2
module tb_spi_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic loop = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] tx_data2 = 8'h96;
  logic busy, done, sclk, cs, mosi, miso;
  logic [7:0] rx_data;
  logic busy2, done2, sclk2, cs2, mosi2;
  logic [7:0] rx_data2;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic [7:0] exp_rx, exp_rx2;
  logic [7:0] q[$];
  logic [7:0] q2[$];
  int done2_t[$];
  int fall2_t[$];
  int tests = 0;
  int fails = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int cyc = 0;
  int cs2_high = 0;
  int cs2_gap_min = 1000;
  logic cs2_prev = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign miso = loop ? mosi : slv_tx[7];

  spi_master #(.HALF_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso)
  );

  spi_master #(.HALF_PERIOD(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx_data2),
    .busy(busy2), .done(done2), .rx_data(rx_data2),
    .sclk(sclk2), .cs(cs2), .mosi(mosi2), .miso(mosi2)
  );

  // Mode-0 slave: presents its MSB on cs fall, shifts out on falling sclk, captures on rising sclk
  always @(negedge cs) slv_tx <= 8'h3C;
  always @(negedge sclk) slv_tx <= {slv_tx[6:0], 1'b0};
  always @(posedge sclk) begin
    slv_rx <= {slv_rx[6:0], mosi};
    rise_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got rx_data %0h expected no done", rx_data);
      end else begin
        exp_rx = q.pop_front();
        check("done_rx_data", rx_data, exp_rx);
      end
    end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      done2_t.push_back(cyc);
      if (q2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done2: got rx_data2 %0h expected no done", rx_data2);
      end else begin
        exp_rx2 = q2.pop_front();
        check("done2_rx_data", rx_data2, exp_rx2);
      end
    end
    if (cs2_prev && !cs2) begin
      fall2_t.push_back(cyc);
      if (fall2_t.size() > 1 && cs2_high < cs2_gap_min) cs2_gap_min = cs2_high;
    end
    cs2_high = cs2 ? cs2_high + 1 : 0;
    cs2_prev = cs2;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      tick(1);
      k++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int d0;
    int k;
    tick(3);
    check("reset_outputs", {cs, sclk, mosi, busy, done, rx_data}, 13'h1000);
    reset = 1'b0;
    loop = 1'b1;
    rise_cnt = 0;
    tx_data = 8'hA5;
    start = 1'b1;
    q.push_back(8'hA5);
    tick(1);
    start = 1'b0;
    check("accept_cs_busy_mosi", {cs, busy, mosi}, 3'b011);
    tick(67);
    check("cs_done_T0_67", {cs, done}, 2'b00);
    tick(1);
    check("cs_done_T0_68", {cs, done}, 2'b11);
    check("rx_A5", rx_data, 8'hA5);
    check("rise_count_A5", rise_cnt, 8);
    tick(3);
    check("busy_T0_71", busy, 1);
    tick(1);
    check("busy_T0_72", busy, 0);
    loop = 1'b0;
    rise_cnt = 0;
    tx_data = 8'hC3;
    start = 1'b1;
    q.push_back(8'h3C);
    tick(1);
    start = 1'b0;
    wait_idle("slave");
    check("slave_captured_C3", slv_rx, 8'hC3);
    check("slave_rise_count", rise_cnt, 8);
    check("master_rx_3C", rx_data, 8'h3C);
    loop = 1'b1;
    d0 = done_cnt;
    tx_data = 8'h5A;
    start = 1'b1;
    q.push_back(8'h5A);
    tick(1);
    start = 1'b0;
    tick(9);
    tx_data = 8'hFF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("ignore");
    check("single_done_pulse", done_cnt - d0, 1);
    check("rx_5A", rx_data, 8'h5A);
    d0 = done_cnt;
    tx_data = 8'h7F;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(19);
    check("pre_reset_mosi", {cs, mosi}, 2'b01);
    reset = 1'b1;
    tick(1);
    check("midframe_reset_outputs", {cs, sclk, mosi, busy, done, rx_data}, 13'h1000);
    tick(2);
    reset = 1'b0;
    tick(80);
    check("no_done_after_abort", done_cnt - d0, 0);
    rise_cnt = 0;
    tx_data = 8'h81;
    start = 1'b1;
    q.push_back(8'h81);
    tick(1);
    start = 1'b0;
    wait_idle("after_reset");
    check("rx_81", rx_data, 8'h81);
    check("rise_count_81", rise_cnt, 8);
    q2.push_back(8'h96);
    q2.push_back(8'h96);
    start2 = 1'b1;
    k = 0;
    while (fall2_t.size() < 2 && k < 200) begin
      tick(1);
      k++;
    end
    start2 = 1'b0;
    check("h2_second_frame_started", fall2_t.size() >= 2, 1);
    k = 0;
    while (busy2 && k < 200) begin
      tick(1);
      k++;
    end
    tick(5);
    check("h2_idle", busy2, 0);
    check("h2_done_count", done2_t.size(), 2);
    if (done2_t.size() >= 2) check("h2_done_spacing", done2_t[1] - done2_t[0], 37);
    if (fall2_t.size() >= 2) check("h2_cs_fall_spacing", fall2_t[1] - fall2_t[0], 37);
    check("h2_cs_gap_ge_h", cs2_gap_min >= 2, 1);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
